// File: rtl/data_ram_if.sv
// Request/response bus between the memory stage and data_ram.
// master = requester, slave = RAM.
interface data_ram_if;
    logic        ce_i;
    logic [3:0]  we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;

    modport master (
        output ce_i, we_i, addr_i, data_i,
        input  data_o, ready_o, err_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, data_i,
        output data_o, ready_o, err_o
    );
endinterface

// File: rtl/data_ram.sv
// Word-addressed data RAM with byte-lane writes, programmable wait states,
// and error reporting for out-of-range and misaligned accesses.
module data_ram #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic       clk,
    input logic       rst,
    data_ram_if.slave bus
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [Depth];

    logic                  from_idle;
    logic                  accept;
    logic                  enter_done;
    logic [3:0]            acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_write;
    logic                  acc_oor;
    logic                  acc_mis;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] acc_idx;

    // Lane pattern must match the byte offset; we[3] is byte offset 0.
    function automatic logic legal_we(input logic [3:0] we, input logic [1:0] off);
        case (we)
            4'b1111, 4'b1100, 4'b1000: return off == 2'b00;
            4'b0100:                   return off == 2'b01;
            4'b0011, 4'b0010:          return off == 2'b10;
            4'b0001:                   return off == 2'b11;
            default:                   return 1'b0;
        endcase
    endfunction

    // With zero wait states the access executes on the accept edge, so it
    // must use the live request rather than the captured copy.
    always_comb begin
        from_idle  = (state_q == StIdle);
        accept     = from_idle && bus.ce_i;
        acc_we     = from_idle ? bus.we_i   : we_q;
        acc_addr   = from_idle ? bus.addr_i : addr_q;
        acc_wdata  = from_idle ? bus.data_i : wdata_q;
        enter_done = !rst && ((accept && (WAIT_CYCLES == 0))
                              || ((state_q == StWait) && (cnt_q == 4'd0)));
        acc_write  = (acc_we != 4'b0000);
        acc_oor    = ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        acc_mis    = acc_write && !legal_we(acc_we, acc_addr[1:0]);
        do_write   = enter_done && acc_write && !acc_oor && !acc_mis;
        acc_idx    = acc_addr[ADDR_WIDTH+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 4'b0000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            bus.data_o  <= 32'h0;
            bus.ready_o <= 1'b0;
            bus.err_o   <= 1'b0;
        end else begin
            bus.ready_o <= 1'b0;
            bus.err_o   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.ce_i) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.data_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (enter_done) begin
                bus.ready_o <= 1'b1;
                bus.err_o   <= acc_oor || acc_mis;
                if (acc_oor) begin
                    bus.data_o <= 32'h0;
                end else if (!acc_write) begin
                    bus.data_o <= mem[acc_idx];
                end
            end
        end
    end

    // No reset on the array: contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_we[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: four instances with WAIT_CYCLES 1, 0, 3, 15.
// Stimulus queues expected responses; a negedge monitor pops and compares.
module tb_data_ram;
    localparam int NDut = 4;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
        bit          chk;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ce    [NDut];
    logic [3:0]  we    [NDut];
    logic [31:0] addr  [NDut];
    logic [31:0] wdata [NDut];
    wire  [31:0] rdata [NDut];
    wire         rdy   [NDut];
    wire         err   [NDut];

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    data_ram_if bus [NDut] ();

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        localparam int unsigned Wc = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
        assign bus[g].ce_i   = ce[g];
        assign bus[g].we_i   = we[g];
        assign bus[g].addr_i = addr[g];
        assign bus[g].data_i = wdata[g];
        assign rdata[g]      = bus[g].data_o;
        assign rdy[g]        = bus[g].ready_o;
        assign err[g]        = bus[g].err_o;
        data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(Wc)) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );
    end

    function automatic int wc(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every ready_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int i = 0; i < NDut; i++) begin
                if (rdy[i] === 1'b1) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_ready dut%0d: got ready_o=1, required 0 (cycle %0d)",
                                 i, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("resp_dut", 32'(i), 32'(e.idx));
                        chk("err_o", {31'd0, err[i]}, {31'd0, e.err});
                        if (e.chk) chk("data_o", rdata[i], e.data);
                        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                end else begin
                    chk("err_without_ready", {31'd0, err[i]}, 32'd0);
                end
            end
        end
    end

    task automatic start(input int i, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] xd, input logic xe,
                         input bit xc);
        exp_t e;
        ce[i]    = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        e.idx  = i;
        e.data = xd;
        e.err  = xe;
        e.chk  = xc;
        e.acc  = cyc + 1;
        e.lat  = wc(i) + 1;
        q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL timeout: got %0d responses outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic finish_req(input int i);
        @(negedge clk);
        // Scramble inputs to show they are ignored once the request is captured.
        ce[i]    = 1'b0;
        we[i]    = 4'(($urandom));
        addr[i]  = $urandom;
        wdata[i] = $urandom;
        #1;
        drain();
    endtask

    task automatic issue(input int i, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] xd, input logic xe,
                         input bit xc);
        @(negedge clk);
        start(i, w, a, d, xd, xe, xc);
        finish_req(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        for (int i = 0; i < NDut; i++) begin
            ce[i] = 1'b0; we[i] = 4'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDut; i++) begin
            chk("reset_data_o", rdata[i], 32'h0);
            chk("reset_ready_o", {31'd0, rdy[i]}, 32'd0);
            chk("reset_err_o", {31'd0, err[i]}, 32'd0);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        // WAIT_CYCLES=1: round trip, lane merge, error paths.
        issue(0, 4'b1111, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b0);
        issue(0, 4'b0000, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b1);
        issue(0, 4'b1111, 32'h20, 32'hAABBCCDD, 32'h12345678, 1'b0, 1'b1);
        issue(0, 4'b0100, 32'h21, 32'h11111111, 32'h0, 1'b0, 1'b0);
        issue(0, 4'b0000, 32'h20, 32'h0, 32'hAA11CCDD, 1'b0, 1'b1);
        issue(0, 4'b0011, 32'h22, 32'h99889988, 32'h0, 1'b0, 1'b0);
        issue(0, 4'b0000, 32'h20, 32'h0, 32'hAA119988, 1'b0, 1'b1);
        issue(0, 4'b1111, 32'h12, 32'hFFFFFFFF, 32'hAA119988, 1'b1, 1'b1);
        issue(0, 4'b0000, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b1);
        issue(0, 4'b0000, 32'h13, 32'h0, 32'h12345678, 1'b0, 1'b1);
        issue(0, 4'b0000, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(0, 4'b0000, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b1);
        issue(0, 4'b1111, 32'h1010, 32'h55555555, 32'h0, 1'b1, 1'b1);
        issue(0, 4'b0000, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b1);
        issue(0, 4'b1111, 32'h30, 32'h00000000, 32'h0, 1'b0, 1'b0);
        issue(0, 4'b0001, 32'h33, 32'h777777EE, 32'h0, 1'b0, 1'b0);
        issue(0, 4'b0000, 32'h30, 32'h0, 32'h000000EE, 1'b0, 1'b1);
        issue(0, 4'b1000, 32'h31, 32'h12121212, 32'h000000EE, 1'b1, 1'b1);
        issue(0, 4'b0000, 32'h30, 32'h0, 32'h000000EE, 1'b0, 1'b1);

        // WAIT_CYCLES=0: latency 1, then held strobe gives pulses on alternate cycles.
        issue(1, 4'b1111, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        a0 = cyc + 1;
        ce[1] = 1'b1; we[1] = 4'b0000; addr[1] = 32'h8; wdata[1] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.idx = 1; e.data = 32'hCAFEF00D; e.err = 1'b0; e.chk = 1'b1;
            e.acc = a0 + 2 * k; e.lat = 1;
            q.push_back(e);
        end
        repeat (6) @(negedge clk);
        ce[1] = 1'b0;
        #1;
        drain();

        // WAIT_CYCLES=15: latency 16.
        issue(3, 4'b1111, 32'h4, 32'h0BADC0DE, 32'h0, 1'b0, 1'b0);
        issue(3, 4'b0000, 32'h4, 32'h0, 32'h0BADC0DE, 1'b0, 1'b1);

        // WAIT_CYCLES=3: reset in the second wait cycle aborts the write.
        issue(2, 4'b1111, 32'h40, 32'h01020304, 32'h0, 1'b0, 1'b0);
        issue(2, 4'b0000, 32'h40, 32'h0, 32'h01020304, 1'b0, 1'b1);
        @(negedge clk);
        ce[2] = 1'b1; we[2] = 4'b1111; addr[2] = 32'h40; wdata[2] = 32'hDEADBEEF;
        @(negedge clk);
        ce[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_abort_data_o", rdata[2], 32'h0);
        chk("rst_abort_ready_o", {31'd0, rdy[2]}, 32'd0);
        chk("rst_abort_err_o", {31'd0, err[2]}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        // First edge after reset release with ce set is accepted.
        start(2, 4'b0000, 32'h40, 32'h0, 32'h01020304, 1'b0, 1'b1);
        finish_req(2);

        chk("queue_empty_at_end", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
